// File: rtl/div_n_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The master side drives the run request and ratio; the slave side is the divider.
interface div_n_prog_if #(
  parameter int DIV_W = 8
);
  logic             en;
  logic [DIV_W-1:0] div;
  logic             clkout;
  logic             tick;
  logic             ratio_err;

  modport master (
    output en,
    output div,
    input  clkout,
    input  tick,
    input  ratio_err
  );

  modport slave (
    input  en,
    input  div,
    output clkout,
    output tick,
    output ratio_err
  );
endinterface

// File: rtl/div_n_prog.sv
// Runtime-programmable 50%-duty clock divider (N = 2..2^DIV_W-1).
// Ratio and enable changes are taken only at period boundaries, so periods never truncate.
module div_n_prog #(
  parameter int DIV_W = 8
) (
  input  logic         clkin,
  input  logic         rst,
  div_n_prog_if.slave  bus
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             run_q, run_d;
  logic             p_q, p_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic             n_q, n_d;

  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W-1:0] div_last;
  logic             bnd;

  // Period boundary detection
  always_comb begin
    cnt_inc  = cnt_q + DIV_W'(1);
    div_last = div_q - DIV_W'(1);
    bnd      = (!run_q) || (cnt_q == div_last);
  end

  // Next-state for all posedge state
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    run_d  = run_q;
    p_d    = p_q;
    tick_d = tick_q;
    err_d  = err_q;
    if (bnd && bus.en) begin
      cnt_d  = DIV_W'(0);
      run_d  = 1'b1;
      tick_d = 1'b1;
      p_d    = 1'b1;
      if (bus.div >= DIV_W'(2)) begin
        div_d = bus.div;
        err_d = 1'b0;
      end else begin
        div_d = DIV_W'(2);
        err_d = 1'b1;
      end
    end else if (bnd) begin
      run_d  = 1'b0;
      p_d    = 1'b0;
      tick_d = 1'b0;
    end else begin
      cnt_d  = cnt_inc;
      tick_d = 1'b0;
      p_d    = (cnt_inc < (div_q >> 1));
    end
  end

  // Posedge state registers with synchronous reset
  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt_q  <= DIV_W'(0);
      div_q  <= DIV_W'(2);
      run_q  <= 1'b0;
      p_q    <= 1'b0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      run_q  <= run_d;
      p_q    <= p_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  // Half-cycle extension is only needed for odd ratios
  always_comb begin
    if (rst) begin
      n_d = 1'b0;
    end else begin
      n_d = div_q[0] & p_q;
    end
  end

  // Negedge extension flop
  always_ff @(negedge clkin) begin
    n_q <= n_d;
  end

  assign bus.clkout    = p_q | n_q;
  assign bus.tick      = tick_q;
  assign bus.ratio_err = err_q;

endmodule

// File: tb/tb_div_n_prog.sv
// Directed bench for div_n_prog: checks clkout per half-cycle, tick and ratio_err
// against hand-derived waveforms for each ratio, change, stop and reset scenario.
module tb_div_n_prog;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  div_n_prog_if #(.DIV_W(8)) bus ();

  div_n_prog #(.DIV_W(8)) dut (
    .clkin (clk),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Walks one full period of n clkin cycles starting at the next posedge.
  // clkout must be high for exactly the first n half-cycles of the 2n.
  task automatic run_period(input string tag, input int n, input logic exp_err,
                            input int chg_c, input logic [7:0] new_div, input logic new_en);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #2;
      chk({tag, "_clk_hi_half"}, bus.clkout, logic'((2 * c) < n));
      chk({tag, "_tick"}, bus.tick, logic'(c == 0));
      chk({tag, "_err"}, bus.ratio_err, exp_err);
      @(negedge clk); #2;
      chk({tag, "_clk_lo_half"}, bus.clkout, logic'((2 * c + 1) < n));
      if (c == chg_c) begin
        bus.div = new_div;
        bus.en  = new_en;
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.div = 8'd5;

    // reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_clkout", bus.clkout, 1'b0);
    chk("rst_tick", bus.tick, 1'b0);
    chk("rst_err", bus.ratio_err, 1'b0);
    @(negedge clk); #2;
    chk("rst_clkout_neg", bus.clkout, 1'b0);

    // divide by 5 straight out of reset
    rst    = 1'b0;
    bus.en = 1'b1;
    run_period("d5a", 5, 1'b0, -1, 8'd0, 1'b0);
    run_period("d5b", 5, 1'b0, -1, 8'd0, 1'b0);

    // even ratio: no half-cycle extension
    bus.div = 8'd4;
    run_period("d4a", 4, 1'b0, -1, 8'd0, 1'b0);
    run_period("d4b", 4, 1'b0, -1, 8'd0, 1'b0);

    // ratio change 3 -> 7 requested mid-period
    bus.div = 8'd3;
    run_period("d3", 3, 1'b0, 0, 8'd7, 1'b1);
    run_period("d7", 7, 1'b0, -1, 8'd0, 1'b0);

    // stop mid-period: current period completes, then clkout stays low
    bus.div = 8'd6;
    run_period("d6", 6, 1'b0, 1, 8'd6, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      chk("idle_clk_p", bus.clkout, 1'b0);
      chk("idle_tick", bus.tick, 1'b0);
      @(negedge clk); #2;
      chk("idle_clk_n", bus.clkout, 1'b0);
    end
    bus.en = 1'b1;
    run_period("d6_restart", 6, 1'b0, -1, 8'd0, 1'b0);

    // illegal ratios fall back to divide-by-2 and flag an error
    bus.div = 8'd1;
    run_period("d1", 2, 1'b1, -1, 8'd0, 1'b0);
    bus.div = 8'd0;
    run_period("d0", 2, 1'b1, -1, 8'd0, 1'b0);
    chk("err_held", bus.ratio_err, 1'b1);
    bus.div = 8'd9;
    run_period("d9", 9, 1'b0, -1, 8'd0, 1'b0);

    // maximum ratio
    bus.div = 8'd255;
    run_period("d255", 255, 1'b0, -1, 8'd0, 1'b0);

    // reset asserted during a high phase of the next 255 period
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #2;
      chk("pre_rst_clk", bus.clkout, 1'b1);
      @(negedge clk); #2;
    end
    rst = 1'b1;
    @(posedge clk); #2;
    chk("rst_mid_tick", bus.tick, 1'b0);
    chk("rst_mid_err", bus.ratio_err, 1'b0);
    @(negedge clk); #2;
    chk("rst_mid_clk_low", bus.clkout, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("rst_hold_clk_p", bus.clkout, 1'b0);
      chk("rst_hold_tick", bus.tick, 1'b0);
      chk("rst_hold_err", bus.ratio_err, 1'b0);
      @(negedge clk); #2;
      chk("rst_hold_clk_n", bus.clkout, 1'b0);
    end

    // fresh period after reset release
    rst     = 1'b0;
    bus.div = 8'd5;
    run_period("post_rst_d5", 5, 1'b0, -1, 8'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_n_prog.md
Name: div_n_prog

Overview:
- Runtime-programmable clock divider. Next generation of the fixed divide-by-5 block.
- Divides clkin by any integer N in 2..2^DIV_W-1.
- Output duty cycle is exactly 50% for both even and odd N. Odd N uses a negedge half-cycle extension.
- Adds three things the fixed divider lacks:
  - glitch-free ratio change,
  - a period-aligned enable,
  - a single-cycle tick in the clkin domain.
- Used to generate slow pixel-config and shift clocks from the fabric clock.

Parameters:
DIV_W, 8, width of the divide-ratio input; maximum ratio is 2^DIV_W-1.

Ports:
clkin      input   1      the only clock; posedge is primary, negedge is used only for odd-N duty correction
rst        input   1      synchronous, active-high reset
en         input   1      run request; start and stop take effect only at period boundaries
div        input   DIV_W  requested divide ratio N; sampled at period boundaries only
clkout     output  1      divided clock, clkout = p | n
tick       output  1      one clkin-cycle pulse, high in the cycle that starts each clkout high phase
ratio_err  output  1      high while the active ratio came from an illegal div (<2)

Behaviour:
- State
  - cnt[DIV_W]: phase counter.
  - div_q[DIV_W]: active ratio.
  - run: running flag.
  - p: posedge phase flop.
  - n: negedge extension flop.
  - err_q.
  - All are posedge flops except n.
- Reset (sampled on posedge; n samples rst on negedge)
  - cnt=0, div_q=2, run=0, p=0, tick=0, err_q=0, n=0.
  - clkout=0, tick=0, ratio_err=0.
- Boundary
  - bnd = (!run) | (cnt == div_q-1).
- Posedge, bnd=1, en=1 (start of a new period)
  - cnt<=0, run<=1, tick<=1, p<=1.
  - If div>=2: div_q<=div, err_q<=0.
  - If div<2: div_q<=2, err_q<=1.
- Posedge, bnd=1, en=0 (stop)
  - run<=0, p<=0, tick<=0.
  - cnt and div_q hold.
- Posedge, bnd=0
  - cnt<=cnt+1, tick<=0.
  - p<=((cnt+1) < (div_q>>1)).
  - div and en are ignored mid-period.
- Negedge
  - n <= rst ? 0 : (div_q[0] & p).
  - For even N, n stays 0.
- Waveform for period N
  - p is high for floor(N/2) posedge cycles from the period start.
  - Odd N: n extends the high phase by half a cycle. High time = N/2 clkin periods, low time = N/2.
  - Even N: high time = low time = N/2 cycles.
- Latency
  - clkout and tick rise at the first posedge where en=1 is sampled with bnd=1.
  - From idle, this is the first posedge with en=1.
- Ratio change
  - A new div takes effect only at the next period start.
  - Every period in flight completes at its old ratio, so there are no runt pulses.
  - Maximum ratio (2^DIV_W-1): cnt counts to 2^DIV_W-2 and never wraps past div_q-1.
- Stop
  - Deasserting en mid-period finishes the current period, then clkout stays low.
  - Re-asserting en starts a fresh period on the next posedge.
  - en toggling within a period has no effect.
- Reset mid-operation
  - p and tick clear at the asserting posedge; n clears at the following negedge.
  - clkout is low no later than one full clkin cycle after reset is sampled. No high pulse may restart until a period start after reset deasserts.
- Simultaneous bnd, en=1 and div change: the new div is loaded and used for the very period that starts.
- ratio_err = err_q; it is held until the next legal load.

Test Plan:
- div=5, en=1 from reset:
  - clkout period = 5 clkin.
  - clkout high 2.5 cycles, rising on posedge and falling on negedge after the 3rd posedge.
  - tick=1 for 1 of every 5 cycles.
  - ratio_err=0.
- div=4: clkout high 2 cycles, low 2 cycles; n never asserts.
- div=3 run, switch div to 7 mid-period:
  - Current 3-cycle period completes.
  - Next period is 7 cycles with 3.5 high.
  - No pulse shorter than 1.5 cycles.
- div=6, drop en at cnt=1:
  - Period completes (3 high, 3 low), then clkout=0 and tick=0 indefinitely.
  - Re-raise en: clkout rises at the first posedge with en=1.
- div=1 then div=0:
  - Both produce a divide-by-2 output with ratio_err=1.
  - Then div=9: ratio_err clears at the next period start; output becomes 9 cycles with 4.5 high.
- div=255 (DIV_W=8), then assert rst during a high phase:
  - Period is 255 cycles with 127.5 high.
  - After rst, clkout is low within 1 clkin cycle; all outputs hold their reset values until rst deasserts.
